// File: rtl/fifo_arb_pkg.sv
// Shared state encoding and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_N_REQ      = 4;
  localparam int DEF_MAX_BURST  = 16;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set req bit strictly after rr_ptr, wrapping.
// Purely combinational; no backpressure of its own.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             vld,
  output logic [IDX_W-1:0] idx
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    vld      = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    // Walk farthest to nearest so the closest requester after rr_ptr wins last.
    for (int off = N_REQ; off >= 1; off--) begin
      cand     = (int'(rr_ptr) + off) % N_REQ;
      cand_idx = IDX_W'(cand);
      if (req[cand_idx]) begin
        vld = 1'b1;
        idx = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-atomic sharing of the FIFO write port; 1-cycle arbitration then 1 beat/cycle.
// FULL stalls the owner in place (no W_EN/ACK); FIFO_WR_ARB_MAX_BURST_EN caps beats per grant.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_REQ      = DEF_N_REQ,
  parameter int IDX_W      = $clog2(N_REQ),
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                        W_CLK,
  input  logic                        W_RST_N,
  input  logic [N_REQ-1:0]            REQ,
  input  logic [N_REQ-1:0]            LAST,
  input  logic [N_REQ*DATA_WIDTH-1:0] DATA,
  input  logic                        FULL,
  output logic [N_REQ-1:0]            ACK,
  output logic [N_REQ-1:0]            GRANT,
  output logic                        W_EN,
  output logic [DATA_WIDTH-1:0]       W_DATA,
  output logic                        BUSY
);

  arb_state_e            state;
  logic [IDX_W-1:0]      gnt_idx;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_vld;
  logic                  busy;
  logic                  accept;
  logic                  burst_cap;
  logic                  release_gnt;
  logic [DATA_WIDTH-1:0] data_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign data_arr[i] = DATA[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (REQ),
    .rr_ptr (rr_ptr),
    .vld    (pick_vld),
    .idx    (pick_idx)
  );

  assign busy        = (state == ARB_BURST);
  assign accept      = busy & REQ[gnt_idx] & ~FULL;
  assign release_gnt = accept & (LAST[gnt_idx] | burst_cap);

  always_comb begin
    GRANT  = '0;
    ACK    = '0;
    W_DATA = '0;
    if (busy) begin
      GRANT[gnt_idx] = 1'b1;
      ACK[gnt_idx]   = accept;
      W_DATA         = data_arr[gnt_idx];
    end
  end

  assign W_EN = accept;
  assign BUSY = busy;

`ifdef FIFO_WR_ARB_MAX_BURST_EN
  logic [7:0] beat_cnt;

  always_ff @(posedge W_CLK or negedge W_RST_N) begin
    if (!W_RST_N) begin
      beat_cnt <= '0;
    end else if (!busy && pick_vld) begin
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= beat_cnt + 8'd1;
    end
  end

  // Reaching the cap releases the port exactly as LAST would; the owner re-arbitrates.
  assign burst_cap = (({1'b0, beat_cnt} + 9'd1) == 9'(MAX_BURST));
`else
  assign burst_cap = 1'b0;
`endif

  always_ff @(posedge W_CLK or negedge W_RST_N) begin
    if (!W_RST_N) begin
      state   <= ARB_IDLE;
      gnt_idx <= '0;
      rr_ptr  <= IDX_W'(N_REQ - 1);
    end else if (!busy) begin
      if (pick_vld) begin
        gnt_idx <= pick_idx;
        state   <= ARB_BURST;
      end
    end else if (release_gnt) begin
      rr_ptr <= gnt_idx;
      state  <= ARB_IDLE;
    end
  end

  ack_onehot: assert property (@(posedge W_CLK) disable iff (!W_RST_N) $onehot0(ACK));
  no_wr_full: assert property (@(posedge W_CLK) disable iff (!W_RST_N) !(W_EN && FULL));
  max_burst_range: assert property (@(posedge W_CLK) (MAX_BURST >= 1) && (MAX_BURST <= 255));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboarded bench for fifo_wr_arbiter: requester queues feed the DUT, a monitor checks every write.
// Behaviour with FIFO_WR_ARB_MAX_BURST_EN follows the same macro (MAX_BURST=4).
module tb_fifo_wr_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;

  typedef struct packed {
    logic [1:0]    idx;
    logic [DW-1:0] dat;
  } exp_t;

  logic              W_CLK   = 1'b0;
  logic              W_RST_N = 1'b0;
  logic [NR-1:0]     REQ     = '0;
  logic [NR-1:0]     LAST    = '0;
  logic [NR*DW-1:0]  DATA    = '0;
  logic              FULL    = 1'b0;
  logic [NR-1:0]     ACK;
  logic [NR-1:0]     GRANT;
  logic              W_EN;
  logic [DW-1:0]     W_DATA;
  logic              BUSY;

  exp_t              exp_q[$];
  logic [8:0]        txq[NR][$];
  logic [NR-1:0]     ack_seen = '0;
  int                checks = 0;
  int                errors = 0;

  always #5 W_CLK = ~W_CLK;

  fifo_wr_arbiter #(
    .DATA_WIDTH (DW),
    .N_REQ      (NR),
    .MAX_BURST  (4)
  ) dut (
    .W_CLK   (W_CLK),
    .W_RST_N (W_RST_N),
    .REQ     (REQ),
    .LAST    (LAST),
    .DATA    (DATA),
    .FULL    (FULL),
    .ACK     (ACK),
    .GRANT   (GRANT),
    .W_EN    (W_EN),
    .W_DATA  (W_DATA),
    .BUSY    (BUSY)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic send(input int r, input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) txq[r].push_back({(k == n - 1), 8'(base + 8'(k))});
  endtask

  task automatic expect_pkt(input int r, input int n, input logic [7:0] base);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.idx = 2'(r);
      e.dat = 8'(base + 8'(k));
      exp_q.push_back(e);
    end
  endtask

  function automatic bit all_idle();
    bit q_empty = 1'b1;
    for (int i = 0; i < NR; i++) if (txq[i].size() != 0) q_empty = 1'b0;
    return q_empty && !BUSY && (exp_q.size() == 0) && (REQ == '0);
  endfunction

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge W_CLK);
      done = all_idle();
    end
    chk({name, "_drained"}, 32'(done), 32'd1);
    chk({name, "_grant_idle"}, 32'(GRANT), 32'd0);
    chk({name, "_busy_idle"}, 32'(BUSY), 32'd0);
  endtask

  task automatic wait_ack(input int r, input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge W_CLK);
      seen = ACK[r];
    end
    chk({name, "_ack_seen"}, 32'(seen), 32'd1);
  endtask

  // Requester model: drop a beat once it was ACKed, then present the next head.
  initial begin
    logic [8:0] b;
    forever begin
      @(posedge W_CLK);
      for (int i = 0; i < NR; i++)
        if (ack_seen[i] && txq[i].size() != 0) void'(txq[i].pop_front());
      #1;
      for (int i = 0; i < NR; i++) begin
        if (txq[i].size() != 0) begin
          b               = txq[i][0];
          REQ[i]          = 1'b1;
          LAST[i]         = b[8];
          DATA[i*DW +: DW] = b[7:0];
        end else begin
          REQ[i]  = 1'b0;
          LAST[i] = 1'b0;
        end
      end
    end
  end

  // Monitor: every write must match the scoreboard head, owner and ACK line.
  initial begin
    exp_t e;
    forever begin
      @(negedge W_CLK);
      if (!W_RST_N) begin
        ack_seen = '0;
      end else begin
        ack_seen = ACK;
        if (FULL) chk("full_blocks_wen", 32'(W_EN), 32'd0);
        if (W_EN) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_write", {24'd0, W_DATA}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("write_data", 32'(W_DATA), 32'(e.dat));
            chk("write_ack", 32'(ACK), 32'(4'b0001 << e.idx));
            chk("write_grant", 32'(GRANT), 32'(4'b0001 << e.idx));
          end
        end else begin
          chk("ack_without_wen", 32'(ACK), 32'd0);
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(negedge W_CLK);
    chk("rst_grant", 32'(GRANT), 32'd0);
    chk("rst_wen", 32'(W_EN), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_wdata", 32'(W_DATA), 32'd0);
    W_RST_N = 1'b1;
    @(negedge W_CLK);

    // Single-beat packet: arbitration cycle, one write, release
    send(0, 1, 8'hA5);
    expect_pkt(0, 1, 8'hA5);
    @(negedge W_CLK);
    chk("t1_arb_grant", 32'(GRANT), 32'd0);
    chk("t1_arb_wen", 32'(W_EN), 32'd0);
    @(negedge W_CLK);
    chk("t1_grant", 32'(GRANT), 32'b0001);
    chk("t1_busy", 32'(BUSY), 32'd1);
    @(negedge W_CLK);
    chk("t1_busy_fall", 32'(BUSY), 32'd0);
    wait_idle("t1");

    // All four contend with single beats; rr_ptr is 0 after t1, req0 has two packets
    send(0, 1, 8'h20); send(1, 1, 8'h21); send(2, 1, 8'h22); send(3, 1, 8'h23);
    send(0, 1, 8'h24);
    expect_pkt(1, 1, 8'h21); expect_pkt(2, 1, 8'h22); expect_pkt(3, 1, 8'h23);
    expect_pkt(0, 1, 8'h20); expect_pkt(0, 1, 8'h24);
    wait_idle("t2");

    // Packet atomicity: req2 arrives mid-packet of req1
    send(1, 4, 8'h10);
    expect_pkt(1, 4, 8'h10);
    expect_pkt(2, 1, 8'h30);
    wait_ack(1, "t3");
    send(2, 1, 8'h30);
    wait_idle("t3");

    // FULL held for 3 cycles on beat 2 of req3's packet
    send(3, 4, 8'h40);
    expect_pkt(3, 4, 8'h40);
    wait_ack(3, "t4");
    @(posedge W_CLK); #1;
    FULL = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge W_CLK);
      chk("t4_full_wen", 32'(W_EN), 32'd0);
      chk("t4_full_ack", 32'(ACK), 32'd0);
      chk("t4_full_grant", 32'(GRANT), 32'b1000);
    end
    @(posedge W_CLK); #1;
    FULL = 1'b0;
    wait_idle("t4");

    // Reset mid-packet of req2 (rr_ptr was moved to 0 first)
    send(0, 1, 8'h5F);
    expect_pkt(0, 1, 8'h5F);
    wait_idle("t5a");
    send(2, 6, 8'h50);
    expect_pkt(2, 1, 8'h50);
    wait_ack(2, "t5");
    @(posedge W_CLK); #3;
    W_RST_N = 1'b0;
    txq[2].delete();
    #1;
    chk("t5_rst_wen", 32'(W_EN), 32'd0);
    chk("t5_rst_grant", 32'(GRANT), 32'd0);
    chk("t5_rst_ack", 32'(ACK), 32'd0);
    chk("t5_rst_busy", 32'(BUSY), 32'd0);
    chk("t5_rst_wdata", 32'(W_DATA), 32'd0);
    repeat (2) @(negedge W_CLK);
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);
    W_RST_N = 1'b1;
    send(0, 1, 8'h60); send(1, 1, 8'h61); send(3, 1, 8'h63);
    expect_pkt(0, 1, 8'h60); expect_pkt(1, 1, 8'h61); expect_pkt(3, 1, 8'h63);
    wait_idle("t5");

    // Long req0 packet against a pending req3
    send(0, 6, 8'h70);
    send(3, 1, 8'h83);
`ifdef FIFO_WR_ARB_MAX_BURST_EN
    expect_pkt(0, 4, 8'h70);
    expect_pkt(3, 1, 8'h83);
    expect_pkt(0, 2, 8'h74);
`else
    expect_pkt(0, 6, 8'h70);
    expect_pkt(3, 1, 8'h83);
`endif
    wait_idle("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
